// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the MM:SS timer blocks (countdown timer and
// the neighbouring stopwatch counters).
//   timer_state_e   : 2-bit FSM state encoding {IDLE, RUN, PAUSE, DONE}
//   SEC_MAX         : last valid seconds value (59)
//   MIN_MAX_DEFAULT : default upper bound for the minutes counter (99)
//   MIN_W / SEC_W   : binary widths of the minutes / seconds counts
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam int MIN_W           = 8;
  localparam int SEC_W           = 6;
  localparam int SEC_MAX         = 59;
  localparam int MIN_MAX_DEFAULT = 99;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

  // Saturate a requested minutes value to the configured maximum.
  function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] value,
                                                 input logic [MIN_W-1:0] limit);
    logic [MIN_W-1:0] result;
    if (value > limit) begin
      result = limit;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // Saturate a requested seconds value to SEC_MAX.
  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] value);
    logic [SEC_W-1:0] result;
    if (value > SEC_W'(SEC_MAX)) begin
      result = SEC_W'(SEC_MAX);
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-second tick. The count runs 0..TICKS_PER_SEC-1
// while en is high and holds its value while en is low, so a paused timer
// keeps its partial second.
//   clk   : system clock
//   rst_n : synchronous active-low reset (count -> 0)
//   en    : advance the count this cycle
//   zero  : synchronous clear of the count (wins over en)
//   tick  : high on the enabled cycle where the count is at its last value
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic zero,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_last_s;

  assign at_last_s = (count_q == LAST);
  assign tick      = en & at_last_s & ~zero;

  // Next-count selection: clear, wrap at the last value, advance or hold.
  always_comb begin
    count_d = count_q;
    if (zero) begin
      count_d = {CNT_W{1'b0}};
    end else if (en) begin
      if (at_last_s) begin
        count_d = {CNT_W{1'b0}};
      end else begin
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Down-counting MM:SS timer. Software loads a preset, start/stop pulses run
// and pause it, minutes borrow into seconds, and reaching 00:00 moves the FSM
// to DONE with a one-cycle expired pulse.
//   clk, rst_n          : clock and synchronous active-low reset
//   clear               : return to IDLE at 00:00
//   load, load_min/sec  : capture a (clamped) preset, return to IDLE
//   start / stop        : resume / pause the countdown (stop wins)
//   min_count/sec_count : binary minutes (0..MAX_MIN) and seconds (0..59)
//   running / done      : state-level flags for RUN / DONE
//   expired             : one-cycle pulse when the count reaches 00:00
// -----------------------------------------------------------------------------
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int MAX_MIN       = MIN_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             start,
  input  logic             stop,
  output logic [MIN_W-1:0] min_count,
  output logic [SEC_W-1:0] sec_count,
  output logic             running,
  output logic             done,
  output logic             expired
);

  localparam logic [MIN_W-1:0] MAX_MIN_L = MIN_W'(MAX_MIN);
  localparam logic [SEC_W-1:0] SEC_MAX_L = SEC_W'(SEC_MAX);

  timer_state_e     state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;

  logic             presc_en_s;
  logic             presc_zero_s;
  logic             tick_s;
  logic             nonzero_s;

  assign nonzero_s = (min_q != {MIN_W{1'b0}}) | (sec_q != {SEC_W{1'b0}});

  // The prescaler only advances in RUN when no higher-priority control is
  // active, so a tick coinciding with clear/load/stop is discarded and the
  // partial second is kept across a pause.
  assign presc_en_s   = (state_q == RUN) & ~clear & ~load & ~stop;
  assign presc_zero_s = clear | load |
                        ((state_q == IDLE) & start & ~stop & nonzero_s);

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (presc_en_s),
    .zero (presc_zero_s),
    .tick (tick_s)
  );

  // Next-state and next-count logic in priority order clear > load > stop > start > tick.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    expired_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      min_d   = {MIN_W{1'b0}};
      sec_d   = {SEC_W{1'b0}};
    end else if (load) begin
      state_d = IDLE;
      min_d   = clamp_min(load_min, MAX_MIN_L);
      sec_d   = clamp_sec(load_sec);
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end else begin
        state_d = state_q;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // Starting from 00:00 would expire immediately; it is ignored.
          if (start && nonzero_s) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        PAUSE: begin
          if (start) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        RUN: begin
          if (tick_s) begin
            if (sec_q != {SEC_W{1'b0}}) begin
              sec_d = sec_q - {{(SEC_W-1){1'b0}}, 1'b1};
              if ((min_q == {MIN_W{1'b0}}) && (sec_q == {{(SEC_W-1){1'b0}}, 1'b1})) begin
                state_d   = DONE;
                expired_d = 1'b1;
              end else begin
                state_d = RUN;
              end
            end else if (min_q != {MIN_W{1'b0}}) begin
              // Borrow: x:00 -> (x-1):59, never reaches 00:00 here.
              min_d   = min_q - {{(MIN_W-1){1'b0}}, 1'b1};
              sec_d   = SEC_MAX_L;
              state_d = RUN;
            end else begin
              // Already 00:00 in RUN cannot normally occur; park in DONE
              // rather than wrap below zero.
              state_d = DONE;
            end
          end else begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
          min_d   = {MIN_W{1'b0}};
          sec_d   = {SEC_W{1'b0}};
        end
        default: begin
          state_d = IDLE;
          min_d   = {MIN_W{1'b0}};
          sec_d   = {SEC_W{1'b0}};
        end
      endcase
    end
  end

  // Status flags are derived from the next state so they register together with it.
  always_comb begin
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // State, counts and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      min_q     <= {MIN_W{1'b0}};
      sec_q     <= {SEC_W{1'b0}};
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign min_count = min_q;
  assign sec_count = sec_q;
  assign running   = running_q;
  assign done      = done_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC=4, MAX_MIN=99.
// Observed word = {min_count, sec_count, running, done, expired}.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_min = 8'd0;
  logic [5:0] load_sec = 6'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] min_count;
  logic [5:0] sec_count;
  logic       running;
  logic       done;
  logic       expired;

  int vectors = 0;
  int miscompares = 0;

  wire [16:0] obs = {min_count, sec_count, running, done, expired};

  countdown_timer #(.TICKS_PER_SEC(4), .MAX_MIN(99)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .stop(stop),
    .min_count(min_count), .sec_count(sec_count), .running(running),
    .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] ev(input int m, input int s, input logic r,
                                     input logic d, input logic e);
    return {8'(m), 6'(s), r, d, e};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int m, input int s);
    load_min = 8'(m);
    load_sec = 6'(s);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    vectors++;
    if (obs !== ev(0, 0, 1'b0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL reset: got %h expected %h", obs, ev(0, 0, 1'b0, 1'b0, 1'b0));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_borrow();
    int v;
    do_load(1, 2);
    pulse_start();
    for (int i = 1; i <= 12; i++) begin
      cyc();
      v = 62 - (i / 4);
      vectors++;
      if (obs !== ev(v / 60, v % 60, 1'b1, 1'b0, 1'b0)) begin
        miscompares++;
        $display("FAIL borrow cyc%0d: got %h expected %h", i, obs, ev(v / 60, v % 60, 1'b1, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_expire();
    logic [16:0] e;
    do_load(0, 2);
    pulse_start();
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i < 4)       e = ev(0, 2, 1'b1, 1'b0, 1'b0);
      else if (i < 8)  e = ev(0, 1, 1'b1, 1'b0, 1'b0);
      else if (i == 8) e = ev(0, 0, 1'b0, 1'b1, 1'b1);
      else             e = ev(0, 0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL expire cyc%0d: got %h expected %h", i, obs, e);
      end
    end
    pulse_start();
    repeat (5) cyc();
    vectors++;
    if (obs !== ev(0, 0, 1'b0, 1'b1, 1'b0)) begin
      miscompares++;
      $display("FAIL done_start: got %h expected %h", obs, ev(0, 0, 1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_pause();
    do_load(0, 5);
    pulse_start();
    repeat (2) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      vectors++;
      if (obs !== ev(0, 5, 1'b0, 1'b0, 1'b0)) begin
        miscompares++;
        $display("FAIL pause cyc%0d: got %h expected %h", i, obs, ev(0, 5, 1'b0, 1'b0, 1'b0));
      end
    end
    pulse_start();
    cyc();
    vectors++;
    if (obs !== ev(0, 5, 1'b1, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL resume+1: got %h expected %h", obs, ev(0, 5, 1'b1, 1'b0, 1'b0));
    end
    cyc();
    vectors++;
    if (obs !== ev(0, 4, 1'b1, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL resume+2: got %h expected %h", obs, ev(0, 4, 1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic test_clamp_zero();
    do_load(150, 63);
    vectors++;
    if (obs !== ev(99, 59, 1'b0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL clamp: got %h expected %h", obs, ev(99, 59, 1'b0, 1'b0, 1'b0));
    end
    do_load(0, 0);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs !== ev(0, 0, 1'b0, 1'b0, 1'b0)) begin
        miscompares++;
        $display("FAIL zero_start cyc%0d: got %h expected %h", i, obs, ev(0, 0, 1'b0, 1'b0, 1'b0));
      end
      cyc();
    end
  endtask

  task automatic test_clear_reset();
    do_load(0, 10);
    pulse_start();
    repeat (3) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    vectors++;
    if (obs !== ev(0, 0, 1'b0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL clear: got %h expected %h", obs, ev(0, 0, 1'b0, 1'b0, 1'b0));
    end
    do_load(0, 3);
    pulse_start();
    repeat (4) cyc();
    vectors++;
    if (obs !== ev(0, 2, 1'b1, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL prereset: got %h expected %h", obs, ev(0, 2, 1'b1, 1'b0, 1'b0));
    end
    rst_n = 1'b0;
    cyc();
    vectors++;
    if (obs !== ev(0, 0, 1'b0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL midrun_reset: got %h expected %h", obs, ev(0, 0, 1'b0, 1'b0, 1'b0));
    end
    rst_n = 1'b1;
    repeat (6) cyc();
    vectors++;
    if (obs !== ev(0, 0, 1'b0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL post_reset: got %h expected %h", obs, ev(0, 0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_start_stop_same();
    do_load(0, 10);
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    vectors++;
    if (obs !== ev(0, 10, 1'b0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL start_stop: got %h expected %h", obs, ev(0, 10, 1'b0, 1'b0, 1'b0));
    end
    repeat (6) cyc();
    vectors++;
    if (obs !== ev(0, 10, 1'b0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL start_stop_hold: got %h expected %h", obs, ev(0, 10, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_load_on_tick();
    do_load(0, 10);
    pulse_start();
    repeat (3) cyc();
    do_load(0, 7);
    vectors++;
    if (obs !== ev(0, 7, 1'b0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL load_tick: got %h expected %h", obs, ev(0, 7, 1'b0, 1'b0, 1'b0));
    end
    pulse_start();
    repeat (3) cyc();
    vectors++;
    if (obs !== ev(0, 7, 1'b1, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL reload_run3: got %h expected %h", obs, ev(0, 7, 1'b1, 1'b0, 1'b0));
    end
    cyc();
    vectors++;
    if (obs !== ev(0, 6, 1'b1, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL reload_run4: got %h expected %h", obs, ev(0, 6, 1'b1, 1'b0, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_borrow();
    test_expire();
    test_pause();
    test_clamp_zero();
    test_clear_reset();
    test_start_stop_same();
    test_load_on_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
